// File: rtl/tdp_bram_be.sv
// tdp_bram_be: true dual-port RAM with per-byte write enables and a zero-clear sweep after reset.
// Latency: read data 1 cycle after re (2 cycles with TDP_BRAM_OUTREG_EN defined); sweep takes DEPTH cycles.
// Backpressure: none; requests while init_busy is high are dropped, never stalled.
module tdp_bram_be #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int WR_MODE    = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic                             init_busy,
    input  logic [ADDR_WIDTH-1:0]            a_addr,
    input  logic                             a_re,
    input  logic                             a_we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_be,
    input  logic [DATA_WIDTH-1:0]            a_wd,
    output logic [DATA_WIDTH-1:0]            a_rd,
    output logic                             a_rvalid,
    input  logic [ADDR_WIDTH-1:0]            b_addr,
    input  logic                             b_re,
    input  logic                             b_we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_be,
    input  logic [DATA_WIDTH-1:0]            b_wd,
    output logic [DATA_WIDTH-1:0]            b_rd,
    output logic                             b_rvalid
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

    generate
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
            $error("tdp_bram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
    endgenerate

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
    logic [DATA_WIDTH-1:0]   a_rd_q, a_rd_d, b_rd_q, b_rd_d;
    logic                    a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   a_mask, b_mask, a_old, b_old;
    logic                    run;

    assign run = (state_q == S_RUN);

    always_comb begin
        a_mask = '0;
        b_mask = '0;
        for (int i = 0; i < NB; i++) begin
            a_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{a_be[i]}};
            b_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{b_be[i]}};
        end
        a_old = mem[a_addr];
        b_old = mem[b_addr];
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == S_INIT) begin
            sweep_d = sweep_q + ADDR_WIDTH'(1);
            if (sweep_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = S_RUN;
            end
        end
    end

    // Write-first only merges the port's own write; the other port's write is never visible here.
    always_comb begin
        a_rd_d     = a_rd_q;
        b_rd_d     = b_rd_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        if (run && a_re) begin
            a_rvalid_d = 1'b1;
            a_rd_d     = (WR_MODE == 1 && a_we) ? ((a_old & ~a_mask) | (a_wd & a_mask)) : a_old;
        end
        if (run && b_re) begin
            b_rvalid_d = 1'b1;
            b_rd_d     = (WR_MODE == 1 && b_we) ? ((b_old & ~b_mask) | (b_wd & b_mask)) : b_old;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            sweep_q    <= '0;
            a_rd_q     <= '0;
            b_rd_q     <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            a_rd_q     <= a_rd_d;
            b_rd_q     <= b_rd_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    // Port A's byte writes are issued last so it wins any byte both ports enable.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[sweep_q] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (b_we && b_be[i]) begin
                    mem[b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_wd[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
            for (int i = 0; i < NB; i++) begin
                if (a_we && a_be[i]) begin
                    mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_wd[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign init_busy = (state_q == S_INIT);

`ifdef TDP_BRAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] a_rd2_q, b_rd2_q;
    logic                  a_rvalid2_q, b_rvalid2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rd2_q     <= '0;
            b_rd2_q     <= '0;
            a_rvalid2_q <= 1'b0;
            b_rvalid2_q <= 1'b0;
        end else begin
            a_rd2_q     <= a_rd_q;
            b_rd2_q     <= b_rd_q;
            a_rvalid2_q <= a_rvalid_q;
            b_rvalid2_q <= b_rvalid_q;
        end
    end

    assign a_rd     = a_rd2_q;
    assign b_rd     = b_rd2_q;
    assign a_rvalid = a_rvalid2_q;
    assign b_rvalid = b_rvalid2_q;
`else
    assign a_rd     = a_rd_q;
    assign b_rd     = b_rd_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
`endif

endmodule

// File: tb/tb_tdp_bram_be.sv
// Bench for tdp_bram_be: directed scenarios plus random dual-port traffic against a word-array model.
module tb_tdp_bram_be;
    localparam int AW      = 4;
    localparam int DW      = 32;
    localparam int BW      = 8;
    localparam int NB      = DW / BW;
    localparam int DEPTH   = 2 ** AW;
    localparam int WR_MODE = 0;
`ifdef TDP_BRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic          init_busy;
    logic [AW-1:0] a_addr, b_addr;
    logic          a_re, a_we, b_re, b_we;
    logic [NB-1:0] a_be, b_be;
    logic [DW-1:0] a_wd, b_wd, a_rd, b_rd;
    logic          a_rvalid, b_rvalid;

    tdp_bram_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .WR_MODE(WR_MODE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_busy(init_busy),
        .a_addr(a_addr), .a_re(a_re), .a_we(a_we), .a_be(a_be), .a_wd(a_wd),
        .a_rd(a_rd), .a_rvalid(a_rvalid),
        .b_addr(b_addr), .b_re(b_re), .b_we(b_we), .b_be(b_be), .b_wd(b_wd),
        .b_rd(b_rd), .b_rvalid(b_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mdl [DEPTH];
    int            since;
    logic [DW-1:0] a_s1, a_s2, b_s1, b_s2;
    logic          a_v1, a_v2, b_v1, b_v2;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[i*BW +: BW] = wd[i*BW +: BW];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        since = 0;
        a_s1 = '0; a_s2 = '0; b_s1 = '0; b_s2 = '0;
        a_v1 = 1'b0; a_v2 = 1'b0; b_v1 = 1'b0; b_v2 = 1'b0;
    endtask

    task automatic clear_inputs();
        a_re = 1'b0; a_we = 1'b0; a_be = '0; a_wd = '0; a_addr = '0;
        b_re = 1'b0; b_we = 1'b0; b_be = '0; b_wd = '0; b_addr = '0;
    endtask

    // One clock with the currently driven inputs; model predicts, then outputs are compared.
    task automatic step();
        logic [DW-1:0] a_old, b_old, a_n, b_n;
        logic          a_vn, b_vn;
        bit            run;
        run   = (since >= DEPTH);
        a_old = mdl[a_addr];
        b_old = mdl[b_addr];
        a_vn  = run && a_re;
        b_vn  = run && b_re;
        a_n   = a_vn ? ((WR_MODE == 1 && a_we) ? merge(a_old, a_wd, a_be) : a_old) : a_s1;
        b_n   = b_vn ? ((WR_MODE == 1 && b_we) ? merge(b_old, b_wd, b_be) : b_old) : b_s1;
        if (run) begin
            if (b_we) mdl[b_addr] = merge(mdl[b_addr], b_wd, b_be);
            if (a_we) mdl[a_addr] = merge(mdl[a_addr], a_wd, a_be);
        end
        @(posedge clk);
        #1;
        since++;
        a_s2 = a_s1; a_v2 = a_v1; a_s1 = a_n; a_v1 = a_vn;
        b_s2 = b_s1; b_v2 = b_v1; b_s1 = b_n; b_v1 = b_vn;
        check("init_busy", 32'(init_busy), 32'(since < DEPTH));
        check("a_rvalid", 32'(a_rvalid), 32'((LAT == 2) ? a_v2 : a_v1));
        check("b_rvalid", 32'(b_rvalid), 32'((LAT == 2) ? b_v2 : b_v1));
        check("a_rd", a_rd, (LAT == 2) ? a_s2 : a_s1);
        check("b_rd", b_rd, (LAT == 2) ? b_s2 : b_s1);
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) step();
    endtask

    // Reads one word on port A and checks it against a value fixed by the caller.
    task automatic read_a(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        clear_inputs();
        a_re = 1'b1; a_addr = addr;
        step();
        idle(LAT - 1);
        check(tag, a_rd, exp);
        check({tag, "_vld"}, 32'(a_rvalid), 32'd1);
    endtask

    // Asserts reset between edges and checks the outputs clear without waiting for a clock.
    task automatic do_reset(input string tag);
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_a_rd"}, a_rd, '0);
        check({tag, "_b_rd"}, b_rd, '0);
        check({tag, "_a_rvalid"}, 32'(a_rvalid), 32'd0);
        check({tag, "_b_rvalid"}, 32'(b_rvalid), 32'd0);
        check({tag, "_busy"}, 32'(init_busy), 32'd1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("por_a_rd", a_rd, '0);
        check("por_busy", 32'(init_busy), 32'd1);
        rst_n = 1'b1;

        // Traffic during the sweep must be dropped; busy is checked on every cycle.
        for (int i = 0; i < DEPTH; i++) begin
            a_re = 1'(1); a_we = 1'(1); a_addr = AW'($urandom_range(DEPTH - 1, 0));
            a_be = NB'($urandom); a_wd = $urandom;
            b_re = 1'(1); b_we = 1'(1); b_addr = AW'($urandom_range(DEPTH - 1, 0));
            b_be = NB'($urandom); b_wd = $urandom;
            step();
        end
        check("busy_after_sweep", 32'(init_busy), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            clear_inputs();
            a_re = 1'b1; a_addr = AW'(i);
            b_re = 1'b1; b_addr = AW'(DEPTH - 1 - i);
            step();
        end
        idle(LAT);
        read_a("sweep_zero_0", 4'd0, 32'h0);
        read_a("sweep_zero_15", 4'd15, 32'h0);

        clear_inputs();
        a_we = 1'b1; a_addr = 4'd3; a_wd = 32'hAABBCCDD; a_be = 4'b0101;
        step();
        read_a("be_partial", 4'd3, 32'h00BB00DD);
        idle(1);
        check("rvalid_single", 32'(a_rvalid), 32'd0);

        clear_inputs();
        a_we = 1'b1; a_addr = 4'd5; a_wd = 32'h11111111; a_be = 4'hF;
        step();
        clear_inputs();
        a_we = 1'b1; a_re = 1'b1; a_addr = 4'd5; a_wd = 32'h22222222; a_be = 4'hF;
        step();
        idle(LAT - 1);
        check("rdw_same_port", a_rd, (WR_MODE == 1) ? 32'h22222222 : 32'h11111111);

        clear_inputs();
        b_we = 1'b1; b_addr = 4'd5; b_wd = 32'h33333333; b_be = 4'hF;
        a_re = 1'b1; a_addr = 4'd5;
        step();
        idle(LAT - 1);
        check("rdw_cross_port", a_rd, 32'h22222222);

        clear_inputs();
        a_we = 1'b1; a_addr = 4'd5; a_wd = 32'hFFFFFFFF; a_be = 4'h0;
        step();
        read_a("be_zero", 4'd5, 32'h33333333);

        clear_inputs();
        a_we = 1'b1; a_addr = 4'd7; a_wd = 32'hAAAAAAAA; a_be = 4'b0011;
        b_we = 1'b1; b_addr = 4'd7; b_wd = 32'hBBBBBBBB; b_be = 4'b0110;
        step();
        read_a("dual_write", 4'd7, 32'h00BBAAAA);

        // Dense random traffic over a small address window so collisions happen often.
        for (int i = 0; i < 400; i++) begin
            a_re = 1'($urandom); a_we = 1'($urandom); a_addr = AW'($urandom_range(7, 0));
            a_be = NB'($urandom); a_wd = $urandom;
            b_re = 1'($urandom); b_we = 1'($urandom); b_addr = AW'($urandom_range(7, 0));
            b_be = NB'($urandom); b_wd = $urandom;
            step();
        end
        idle(LAT);

        clear_inputs();
        a_we = 1'b1; a_addr = 4'd2; a_wd = 32'h5A5A5A5A; a_be = 4'hF;
        step();
        read_a("pre_reset_val", 4'd2, 32'h5A5A5A5A);
        do_reset("rst_run");
        idle(8);
        do_reset("rst_sweep");
        idle(DEPTH);
        read_a("post_reset_zero", 4'd2, 32'h0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tdp_bram_be.md
TDP_BRAM_BE -- requirements
Module: tdp_bram_be

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, the address bits per port; DEPTH = 2**ADDR_WIDTH words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the word width for both ports.
REQ-003 The block SHALL have parameter BYTE_WIDTH, default 8, the bits controlled by one byte-enable.
REQ-004 The block SHALL have parameter WR_MODE, default 0, selecting same-port read-during-write behaviour: 0 = read-first, 1 = write-first.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-008 The block SHALL have port init_busy, output, 1 bit, high while the post-reset clear sweep runs.
REQ-009 The block SHALL have ports a_addr and b_addr, input, ADDR_WIDTH bits, the word address.
REQ-010 The block SHALL have ports a_re and b_re, input, 1 bit, read enable.
REQ-011 The block SHALL have ports a_we and b_we, input, 1 bit, write enable.
REQ-012 The block SHALL have ports a_be and b_be, input, DATA_WIDTH/BYTE_WIDTH bits, byte enables; bit i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-013 The block SHALL have ports a_wd and b_wd, input, DATA_WIDTH bits, write data.
REQ-014 The block SHALL have ports a_rd and b_rd, output, DATA_WIDTH bits, registered read data.
REQ-015 The block SHALL have ports a_rvalid and b_rvalid, output, 1 bit, a one-cycle pulse marking new data on the rd output.

Function
REQ-016 The block SHALL fail elaboration if DATA_WIDTH is not an integer multiple of BYTE_WIDTH.
REQ-017 The block SHALL run a two-state FSM: INIT, then RUN. It enters INIT on reset. In INIT it writes zero to the address held by a sweep counter (0 to DEPTH-1), one word per cycle. After writing DEPTH-1 it moves to RUN. init_busy SHALL equal (state == INIT).
REQ-018 The block SHALL ignore all port requests in INIT: writes are dropped, no rvalid pulses, rd holds its value; the first accepted request is in the first RUN cycle, exactly DEPTH cycles after rst_n deasserts.
REQ-019 In RUN, a write SHALL occur when we=1: only bytes with be[i]=1 are updated; we=1 with be=0 SHALL leave memory unchanged.
REQ-020 In RUN, a read SHALL occur when re=1: rd and rvalid are updated at the next edge (latency 1); rvalid=1 for that one cycle; with re=0, rd holds its value and rvalid=0.
REQ-021 For re=1 and we=1 on the same port and address: WR_MODE=0 SHALL return the pre-write word; WR_MODE=1 SHALL return the post-write merged word.
REQ-022 When both ports write the same address in one cycle, the resolution SHALL be per byte: bytes enabled on A take a_wd; bytes enabled only on B take b_wd; port A wins on overlap.
REQ-023 A read on one port while the other port writes the same address SHALL return the pre-write word, independent of WR_MODE.
REQ-024 Accesses to different addresses on the two ports SHALL be fully independent, with no stall.

Reset
REQ-025 On rst_n low (asynchronous), the block SHALL set a_rd=b_rd=0, a_rvalid=b_rvalid=0, state=INIT, init_busy=1 and sweep counter=0; memory is cleared only by the sweep.
REQ-026 Reset asserted mid-sweep or mid-RUN SHALL restart the sweep from address 0; no partial write from the reset cycle SHALL persist.

Configuration
REQ-027 With macro TDP_BRAM_OUTREG_EN defined, the block SHALL add one output register stage per port: read latency 2, rvalid delayed to align with rd, and both stages reset to 0.
REQ-028 Without TDP_BRAM_OUTREG_EN, the read latency SHALL be 1 as specified in REQ-020; all other behaviour is identical in both builds.

Verification (ADDR_WIDTH=4, DATA_WIDTH=32, BYTE_WIDTH=8)
REQ-029 Release rst_n, idle -> init_busy high for exactly 16 cycles; then reads of addresses 0..15 return 0x00000000.
REQ-030 A writes 0xAABBCCDD to address 3 with be=4'b0101, then A reads address 3 -> 0x00BB00DD, with a single rvalid pulse one cycle later (two cycles with TDP_BRAM_OUTREG_EN).
REQ-031 Address 5 = 0x11111111; A writes 0x22222222 and reads address 5 in the same cycle, be=4'hF -> rd=0x11111111 with WR_MODE=0; rd=0x22222222 with WR_MODE=1.
REQ-032 A writes 0xAAAAAAAA with be=4'b0011 and B writes 0xBBBBBBBB with be=4'b0110 to address 7 in the same cycle -> address 7 reads 0x00BBAAAA.
REQ-033 Assert rst_n low at sweep cycle 8 after address 2 holds a nonzero value -> outputs go to 0 immediately; after release, init_busy stays high for a full 16 cycles and address 2 reads 0.
